// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of one combinational 32-bit shifter,
// with a single registered output entry tagged with the winning port.
module shift_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SA_W       = 5,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [SA_W-1:0]   req_sa0,
  input  logic [SA_W-1:0]   req_sa1,
  input  logic [1:0]        req_right,
  input  logic [1:0]        req_arith,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                prio_q,  prio_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic                can_accept;
  logic [1:0]          accept;
  logic                win;
  logic [DATA_W-1:0]   op_data;
  logic [SA_W-1:0]     op_sa;
  logic                op_right;
  logic                op_arith;
  logic [DATA_W-1:0]   shift_res;

  // The output entry can take a new op when empty or when it drains this cycle.
  assign can_accept = (state_q == EMPTY) | ((state_q == FULL) & rsp_ready[grant_q]);

  // Grant never looks at a port's own valid, only at the competitor's.
  assign req_ready[0] = can_accept & ~rst & (~req_valid[1] | ~prio_q);
  assign req_ready[1] = can_accept & ~rst & (~req_valid[0] |  prio_q);

  assign accept = req_valid & req_ready;
  assign win    = accept[1];

  always_comb begin
    op_data  = win ? req_data1 : req_data0;
    op_sa    = win ? req_sa1   : req_sa0;
    op_right = req_right[win];
    op_arith = req_arith[win];
  end

  always_comb begin
    shift_res = op_data;
    if (!op_right) begin
      shift_res = op_data << op_sa;
    end else if (op_arith) begin
      shift_res = $unsigned($signed(op_data) >>> op_sa);
    end else begin
      shift_res = op_data >> op_sa;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    prio_d   = prio_q;
    result_d = result_q;
    if (|accept) begin
      state_d  = FULL;
      grant_d  = win;
      prio_d   = ~win;
      result_d = shift_res;
    end else if ((state_q == FULL) && rsp_ready[grant_q]) begin
      state_d  = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      grant_q  <= 1'b0;
      prio_q   <= 1'(RESET_PRIO);
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      prio_q   <= prio_d;
      result_q <= result_d;
    end
  end

  assign busy       = (state_q == FULL);
  assign grant_id   = grant_q;
  assign rsp_result = result_q;
  assign rsp_valid  = {busy & grant_q, busy & ~grant_q};

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_right, req_arith;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [31:0] req_data0, req_data1, rsp_result;
  logic [4:0]  req_sa0, req_sa1;
  logic        busy, grant_id;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: one optional pending response and the priority pointer.
  bit        m_full;
  bit        m_owner;
  bit        m_prio;
  bit [31:0] m_res;

  shift_arbiter #(.DATA_W(32), .SA_W(5), .RESET_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_sa0(req_sa0), .req_sa1(req_sa1),
    .req_right(req_right), .req_arith(req_arith),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Shift computed with plain arithmetic: multiply/divide by 2**sa.
  function automatic bit [31:0] shift_ref(bit [31:0] d, int sa, bit r, bit a);
    longint unsigned p = 64'd1 << sa;
    longint unsigned v = {32'd0, d};
    longint unsigned nv = {32'd0, ~d};
    if (!r) return 32'((v * p) % 64'h1_0000_0000);
    if (!a || !d[31]) return 32'(v / p);
    return ~32'(nv / p);
  endfunction

  function automatic bit [1:0] ref_ready(bit [1:0] v, bit [1:0] rr);
    bit can = !m_full || rr[m_owner];
    bit [1:0] r;
    r[0] = can && (!v[1] || m_prio == 1'b0);
    r[1] = can && (!v[0] || m_prio == 1'b1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 2'b00; req_right = 2'b00; req_arith = 2'b00; rsp_ready = 2'b00;
    req_data0 = '0; req_data1 = '0; req_sa0 = '0; req_sa1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_full = 0; m_owner = 0; m_prio = 0; m_res = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    req_valid = 2'b11;
    #2;
    tests_run++;
    if (req_ready !== 2'b00) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 00", req_ready);
    end
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 32'h0 || grant_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got valid=%b busy=%b res=%h gid=%b expected 00 0 0 0",
               rsp_valid, busy, rsp_result, grant_id);
    end
  endtask

  task automatic test_port0_arith();
    req_valid = 2'b01; req_data0 = 32'h8000_0000; req_sa0 = 5'd4;
    req_right = 2'b01; req_arith = 2'b01; rsp_ready = 2'b00;
    #2;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++; $display("FAIL p0_ready: got %b expected 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'hF800_0000 || grant_id !== 1'b0) begin
      tests_failed++;
      $display("FAIL p0_result: got valid=%b res=%h gid=%b expected 01 f8000000 0",
               rsp_valid, rsp_result, grant_id);
    end
    rsp_ready = 2'b01;
    tick();
    tests_run++;
    if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
      tests_failed++; $display("FAIL p0_drain: got busy=%b valid=%b expected 0 00", busy, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 2'b10; req_data1 = 32'h8000_0000; req_sa1 = 5'd4;
    req_right = 2'b10; req_arith = 2'b00; rsp_ready = 2'b10;
    #2;
    tests_run++;
    if (req_ready[1] !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_ready1: got %b expected 1", req_ready[1]);
    end
    tick();
    req_data1 = 32'h0000_000F; req_sa1 = 5'd8; req_right = 2'b00;
    #2;
    tests_run++;
    if (rsp_valid !== 2'b10 || rsp_result !== 32'h0800_0000 || grant_id !== 1'b1 || req_ready[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_first: got valid=%b res=%h gid=%b rdy=%b expected 10 08000000 1 x1",
               rsp_valid, rsp_result, grant_id, req_ready);
    end
    tick();
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 2'b10 || rsp_result !== 32'h0000_0F00 || grant_id !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second: got valid=%b res=%h gid=%b expected 10 00000f00 1",
               rsp_valid, rsp_result, grant_id);
    end
    tick();
  endtask

  task automatic test_alternate();
    bit [31:0] e;
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_data0 = 32'h1234_5678; req_sa0 = 5'd3; req_right = 2'b10; req_arith = 2'b10;
    req_data1 = 32'h9000_0001; req_sa1 = 5'd2;
    for (int k = 0; k < 8; k++) begin
      #2;
      tests_run++;
      if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        tests_failed++; $display("FAIL alt_ready[%0d]: got %b expected %b", k, req_ready,
                                 (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
      e = (k % 2 == 0) ? shift_ref(32'h1234_5678, 3, 0, 0) : shift_ref(32'h9000_0001, 2, 1, 1);
      tests_run++;
      if (rsp_valid !== ((k % 2 == 0) ? 2'b01 : 2'b10) || rsp_result !== e || grant_id !== 1'(k % 2)) begin
        tests_failed++;
        $display("FAIL alt_rsp[%0d]: got valid=%b res=%h gid=%b expected res=%h gid=%0d",
                 k, rsp_valid, rsp_result, grant_id, e, k % 2);
      end
    end
    idle_inputs();
    rsp_ready = 2'b11;
    tick();
  endtask

  task automatic test_backpressure();
    bit [31:0] held;
    do_reset();
    req_valid = 2'b01; req_data0 = 32'h0000_00F0; req_sa0 = 5'd4; req_right = 2'b00;
    tick();
    held = 32'h0000_0F00;
    req_valid = 2'b10; req_data1 = 32'hFFFF_0000; req_sa1 = 5'd16; req_right = 2'b10; req_arith = 2'b00;
    rsp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      #2;
      tests_run++;
      if (req_ready !== 2'b00 || rsp_result !== held || rsp_valid !== 2'b01 || grant_id !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got rdy=%b res=%h valid=%b gid=%b expected 00 %h 01 0",
                 k, req_ready, rsp_result, rsp_valid, grant_id, held);
      end
      tick();
    end
    rsp_ready = 2'b01;
    #2;
    tests_run++;
    if (req_ready !== 2'b10) begin
      tests_failed++; $display("FAIL bp_release_ready: got %b expected 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tests_run++;
    if (rsp_valid !== 2'b10 || grant_id !== 1'b1 || rsp_result !== 32'h0000_FFFF) begin
      tests_failed++;
      $display("FAIL bp_release_rsp: got valid=%b gid=%b res=%h expected 10 1 0000ffff",
               rsp_valid, grant_id, rsp_result);
    end
    rsp_ready = 2'b11;
    tick();
  endtask

  task automatic test_boundaries();
    bit [31:0] d  [5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h8000_0000};
    bit [4:0]  sa [5] = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd31};
    bit        r  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit        a  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit [31:0] e  [5] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF};
    rsp_ready = 2'b01;
    for (int k = 0; k < 5; k++) begin
      req_valid = 2'b01; req_data0 = d[k]; req_sa0 = sa[k];
      req_right = {1'b0, r[k]}; req_arith = {1'b0, a[k]};
      tick();
      tests_run++;
      if (rsp_valid !== 2'b01 || rsp_result !== e[k]) begin
        tests_failed++;
        $display("FAIL boundary[%0d]: got valid=%b res=%h expected 01 %h", k, rsp_valid, rsp_result, e[k]);
      end
    end
    idle_inputs();
    rsp_ready = 2'b01;
    tick();
  endtask

  task automatic test_reset_midop();
    req_valid = 2'b01; req_data0 = 32'h5555_AAAA; req_sa0 = 5'd1; rsp_ready = 2'b00;
    tick();
    req_valid = 2'b10; req_data1 = 32'h1; req_sa1 = 5'd1;
    tick();
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    rst = 1'b0;
    tests_run++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_state: got valid=%b busy=%b res=%h expected 00 0 0", rsp_valid, busy, rsp_result);
    end
    rsp_ready = 2'b11;
    #2;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++; $display("FAIL midrst_prio: got %b expected 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    tests_run++;
    if (grant_id !== 1'b0 || rsp_valid !== 2'b01 || rsp_result !== 32'hAAAB_5554) begin
      tests_failed++;
      $display("FAIL midrst_grant: got gid=%b valid=%b res=%h expected 0 01 aaab5554",
               grant_id, rsp_valid, rsp_result);
    end
    tick();
  endtask

  task automatic test_random();
    bit [1:0] exp_rdy;
    bit       acc;
    bit       win;
    int       wait_cnt [2];
    do_reset();
    wait_cnt[0] = 0; wait_cnt[1] = 0;
    for (int c = 0; c < 400; c++) begin
      // Requesters keep valid and payload stable until accepted.
      if (!req_valid[0] && $urandom_range(0, 2) != 0) begin
        req_valid[0] = 1'b1; req_data0 = $urandom; req_sa0 = 5'($urandom);
        req_right[0] = 1'($urandom); req_arith[0] = 1'($urandom);
      end
      if (!req_valid[1] && $urandom_range(0, 2) != 0) begin
        req_valid[1] = 1'b1; req_data1 = $urandom; req_sa1 = 5'($urandom);
        req_right[1] = 1'($urandom); req_arith[1] = 1'($urandom);
      end
      rsp_ready = 2'($urandom);
      #2;
      exp_rdy = ref_ready(req_valid, rsp_ready);
      tests_run++;
      if (req_ready !== exp_rdy) begin
        tests_failed++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, req_ready, exp_rdy);
      end
      acc = |(req_valid & exp_rdy);
      win = req_valid[1] & exp_rdy[1];
      if (acc) begin
        m_res   = win ? shift_ref(req_data1, int'(req_sa1), req_right[1], req_arith[1])
                      : shift_ref(req_data0, int'(req_sa0), req_right[0], req_arith[0]);
        m_full  = 1; m_owner = win; m_prio = ~win;
      end else if (m_full && rsp_ready[m_owner]) begin
        m_full = 0;
      end
      for (int p = 0; p < 2; p++) wait_cnt[p] = (req_valid[p] && !exp_rdy[p]) ? wait_cnt[p] + 1 : 0;
      tick();
      if (acc) req_valid[win] = 1'b0;
      tests_run++;
      if (busy !== m_full || rsp_valid !== (m_full ? (m_owner ? 2'b10 : 2'b01) : 2'b00) ||
          (m_full && (grant_id !== m_owner || rsp_result !== m_res))) begin
        tests_failed++;
        $display("FAIL rnd_rsp[%0d]: got busy=%b valid=%b gid=%b res=%h expected busy=%b gid=%b res=%h",
                 c, busy, rsp_valid, grant_id, rsp_result, m_full, m_owner, m_res);
      end
    end
    idle_inputs();
    rsp_ready = 2'b11;
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    test_reset();
    test_port0_arith();
    test_back_to_back();
    test_alternate();
    test_backpressure();
    test_boundaries();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
